// File: rtl/bram_dual_arbiter.sv
// Round-robin arbiter sharing a true dual-port BRAM between NUM_REQ requesters; reads return 1 cycle after acceptance
// (2 with BRAM_DUAL_ARBITER_RSP_REG_EN). Backpressure: REQ_READY is a same-cycle grant; port-B reads stall while responses are queued.
module bram_dual_arbiter #(
    parameter int  ADDR_WIDTH = 10,
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_REQ    = 4,
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [NUM_REQ-1:0]             REQ_VALID,
    output logic [NUM_REQ-1:0]             REQ_READY,
    input  logic [NUM_REQ-1:0]             REQ_WE,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  REQ_ADDR,
    input  logic [NUM_REQ*BE_WIDTH-1:0]    REQ_BE,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  REQ_DATA,
    output logic [NUM_REQ-1:0]             RSP_VALID,
    output logic [DATA_WIDTH-1:0]          RSP_DATA,
    output logic [ADDR_WIDTH-1:0]          ADDR_A,
    output logic [DATA_WIDTH-1:0]          DI_A,
    output logic                           WE_A,
    output logic [BE_WIDTH-1:0]            BE_A,
    output logic [ADDR_WIDTH-1:0]          ADDR_B,
    output logic [DATA_WIDTH-1:0]          DI_B,
    output logic                           WE_B,
    output logic [BE_WIDTH-1:0]            BE_B,
    input  logic [DATA_WIDTH-1:0]          DO_A,
    input  logic [DATA_WIDTH-1:0]          DO_B
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
    logic [BE_WIDTH-1:0]   req_be   [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_dat  [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i] = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
            req_be[i]   = REQ_BE[i*BE_WIDTH +: BE_WIDTH];
            req_dat[i]  = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // State
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  rd_a_vld_q, rd_a_vld_d;
    logic [ID_W-1:0]       rd_a_id_q, rd_a_id_d;
    logic                  rd_b_vld_q, rd_b_vld_d;
    logic [ID_W-1:0]       rd_b_id_q, rd_b_id_d;
    logic [1:0]            pend_cnt_q, pend_cnt_d;
    logic [ID_W-1:0]       pend_id_q  [2];
    logic [ID_W-1:0]       pend_id_d  [2];
    logic [DATA_WIDTH-1:0] pend_dat_q [2];
    logic [DATA_WIDTH-1:0] pend_dat_d [2];

    // Arbitration
    logic            a_fnd, b_fnd;
    logic [ID_W-1:0] a_id, b_id, cand;
    logic            b_rd_block;
    logic            a_gnt, b_gnt;

    // A queued response means port B may only take writes this cycle.
    assign b_rd_block = (pend_cnt_q != 2'd0);

    always_comb begin
        a_fnd = 1'b0;
        b_fnd = 1'b0;
        a_id  = '0;
        b_id  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!a_fnd) begin
                if (REQ_VALID[cand]) begin
                    a_fnd = 1'b1;
                    a_id  = cand;
                end
            end else if (!b_fnd && REQ_VALID[cand]) begin
                if (!((req_addr[cand] == req_addr[a_id]) && (REQ_WE[cand] || REQ_WE[a_id])) &&
                    !(b_rd_block && !REQ_WE[cand])) begin
                    b_fnd = 1'b1;
                    b_id  = cand;
                end
            end
        end
    end

    assign a_gnt = a_fnd & RST_N;
    assign b_gnt = b_fnd & RST_N;

    always_comb begin
        REQ_READY = '0;
        if (a_gnt) REQ_READY = REQ_READY | (NUM_REQ'(1) << a_id);
        if (b_gnt) REQ_READY = REQ_READY | (NUM_REQ'(1) << b_id);
    end

    always_comb begin
        ADDR_A = '0;
        DI_A   = '0;
        WE_A   = 1'b0;
        BE_A   = '0;
        ADDR_B = '0;
        DI_B   = '0;
        WE_B   = 1'b0;
        BE_B   = '0;
        if (a_gnt) begin
            ADDR_A = req_addr[a_id];
            DI_A   = req_dat[a_id];
            WE_A   = REQ_WE[a_id];
            BE_A   = req_be[a_id];
        end
        if (b_gnt) begin
            ADDR_B = req_addr[b_id];
            DI_B   = req_dat[b_id];
            WE_B   = REQ_WE[b_id];
            BE_B   = req_be[b_id];
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        rd_a_vld_d = a_fnd & ~REQ_WE[a_id];
        rd_a_id_d  = a_id;
        rd_b_vld_d = b_fnd & ~REQ_WE[b_id];
        rd_b_id_d  = b_id;
        if (a_fnd) begin
            ptr_d = (a_id == ID_W'(NUM_REQ - 1)) ? '0 : a_id + 1'b1;
        end
    end

    // Response ordering: queued entries first, then this cycle's port-A and port-B read data.
    logic [ID_W-1:0]       lst_id  [4];
    logic [DATA_WIDTH-1:0] lst_dat [4];
    int                    lst_n;
    logic                  out_vld;
    logic [ID_W-1:0]       out_id;
    logic [DATA_WIDTH-1:0] out_dat;

    always_comb begin
        lst_n = 0;
        for (int j = 0; j < 4; j++) begin
            lst_id[j]  = '0;
            lst_dat[j] = '0;
        end
        for (int j = 0; j < 2; j++) begin
            if (j < int'(pend_cnt_q)) begin
                lst_id[lst_n]  = pend_id_q[j];
                lst_dat[lst_n] = pend_dat_q[j];
                lst_n          = lst_n + 1;
            end
        end
        if (rd_a_vld_q) begin
            lst_id[lst_n]  = rd_a_id_q;
            lst_dat[lst_n] = DO_A;
            lst_n          = lst_n + 1;
        end
        if (rd_b_vld_q) begin
            lst_id[lst_n]  = rd_b_id_q;
            lst_dat[lst_n] = DO_B;
            lst_n          = lst_n + 1;
        end
        out_vld       = (lst_n > 0);
        out_id        = lst_id[0];
        out_dat       = out_vld ? lst_dat[0] : '0;
        pend_id_d[0]  = lst_id[1];
        pend_id_d[1]  = lst_id[2];
        pend_dat_d[0] = lst_dat[1];
        pend_dat_d[1] = lst_dat[2];
        if (lst_n >= 3)      pend_cnt_d = 2'd2;
        else if (lst_n == 2) pend_cnt_d = 2'd1;
        else                 pend_cnt_d = 2'd0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q      <= '0;
            rd_a_vld_q <= 1'b0;
            rd_a_id_q  <= '0;
            rd_b_vld_q <= 1'b0;
            rd_b_id_q  <= '0;
            pend_cnt_q <= 2'd0;
            for (int j = 0; j < 2; j++) begin
                pend_id_q[j]  <= '0;
                pend_dat_q[j] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            rd_a_vld_q <= rd_a_vld_d;
            rd_a_id_q  <= rd_a_id_d;
            rd_b_vld_q <= rd_b_vld_d;
            rd_b_id_q  <= rd_b_id_d;
            pend_cnt_q <= pend_cnt_d;
            for (int j = 0; j < 2; j++) begin
                pend_id_q[j]  <= pend_id_d[j];
                pend_dat_q[j] <= pend_dat_d[j];
            end
        end
    end

    logic [NUM_REQ-1:0] rsp_vld_d;
    assign rsp_vld_d = out_vld ? (NUM_REQ'(1) << out_id) : '0;

`ifdef BRAM_DUAL_ARBITER_RSP_REG_EN
    logic [NUM_REQ-1:0]    rsp_vld_q;
    logic [DATA_WIDTH-1:0] rsp_dat_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rsp_vld_q <= '0;
            rsp_dat_q <= '0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= out_dat;
        end
    end

    assign RSP_VALID = rsp_vld_q;
    assign RSP_DATA  = rsp_dat_q;
`else
    assign RSP_VALID = rsp_vld_d;
    assign RSP_DATA  = out_dat;
`endif

endmodule

// File: tb/tb_bram_dual_arbiter.sv
// Directed bench for bram_dual_arbiter with a behavioural dual-port RAM and an in-order read-response scoreboard.
module tb_bram_dual_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int BW = DW / 8;
    localparam logic [DW-1:0] PRE = 32'hA0A0_0000;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [N-1:0]    REQ_VALID, REQ_READY, REQ_WE, RSP_VALID;
    logic [N*AW-1:0] REQ_ADDR;
    logic [N*BW-1:0] REQ_BE;
    logic [N*DW-1:0] REQ_DATA;
    logic [DW-1:0]   RSP_DATA, DI_A, DI_B, DO_A, DO_B;
    logic [AW-1:0]   ADDR_A, ADDR_B;
    logic            WE_A, WE_B;
    logic [BW-1:0]   BE_A, BE_B;

    always #5 CLK = ~CLK;

    bram_dual_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_BE(REQ_BE), .REQ_DATA(REQ_DATA),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
        .ADDR_A(ADDR_A), .DI_A(DI_A), .WE_A(WE_A), .BE_A(BE_A),
        .ADDR_B(ADDR_B), .DI_B(DI_B), .WE_B(WE_B), .BE_B(BE_B),
        .DO_A(DO_A), .DO_B(DO_B)
    );

    // Behavioural true dual-port RAM, one-cycle read latency, byte-enabled writes.
    logic [DW-1:0] mem [1<<AW];
    always @(posedge CLK) begin
        if (WE_A) begin
            for (int b = 0; b < BW; b++) if (BE_A[b]) mem[ADDR_A][8*b +: 8] <= DI_A[8*b +: 8];
        end else begin
            DO_A <= mem[ADDR_A];
        end
        if (WE_B) begin
            for (int b = 0; b < BW; b++) if (BE_B[b]) mem[ADDR_B][8*b +: 8] <= DI_B[8*b +: 8];
        end else begin
            DO_B <= mem[ADDR_B];
        end
    end

    typedef struct {
        int            id;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    exp_t mon_e;
    int   mon_id;
    always @(negedge CLK) begin
        if (RSP_VALID != '0) begin
            chk("rsp_onehot", 64'($onehot(RSP_VALID)), 64'd1);
            mon_id = 0;
            for (int b = 0; b < N; b++) if (RSP_VALID[b]) mon_id = b;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(RSP_VALID), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id", 64'(mon_id), 64'(mon_e.id));
                chk("rsp_data", 64'(RSP_DATA), 64'(mon_e.dat));
            end
        end
    end

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [BW-1:0] be, input logic [DW-1:0] d);
        REQ_VALID[i]          = 1'b1;
        REQ_WE[i]             = we;
        REQ_ADDR[i*AW +: AW]  = a;
        REQ_BE[i*BW +: BW]    = be;
        REQ_DATA[i*DW +: DW]  = d;
    endtask

    task automatic rd(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.id  = i;
        e.dat = d;
        exp_q.push_back(e);
        set_req(i, 1'b0, a, 4'hF, '0);
    endtask

    // One clock cycle starting at a falling edge; returns this cycle's accepted requesters.
    task automatic cyc(output logic [N-1:0] g);
        #1;
        g = REQ_VALID & REQ_READY;
        @(negedge CLK);
        REQ_VALID = REQ_VALID & ~g;
    endtask

    task automatic cyc_chk(input string tag, input logic [N-1:0] exp_g);
        logic [N-1:0] g;
        cyc(g);
        chk(tag, 64'(g), 64'(exp_g));
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(negedge CLK);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] g;
        logic         got;
        RST_N     = 1'b0;
        REQ_VALID = '0;
        REQ_WE    = '0;
        REQ_ADDR  = '0;
        REQ_BE    = '0;
        REQ_DATA  = '0;
        repeat (2) @(negedge CLK);

        // Reset: requests present but nothing granted or driven
        REQ_VALID = '1;
        #1;
        chk("rst_ready", 64'(REQ_READY), 64'd0);
        chk("rst_we_a", 64'(WE_A), 64'd0);
        chk("rst_we_b", 64'(WE_B), 64'd0);
        chk("rst_be_a", 64'(BE_A), 64'd0);
        chk("rst_be_b", 64'(BE_B), 64'd0);
        chk("rst_rsp_vld", 64'(RSP_VALID), 64'd0);
        chk("rst_rsp_dat", 64'(RSP_DATA), 64'd0);
        REQ_VALID = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Preload addresses 1..4 with four writes
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), 4'hF, PRE + DW'(i + 1));
        cyc_chk("pre_c0", 4'b0011);
        cyc_chk("pre_c1", 4'b1100);

        // Reset with reads in flight: responses are discarded
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i + 1), 4'hF, '0);
        @(posedge CLK);
        #1 RST_N = 1'b0;
        @(negedge CLK);
        #1;
        chk("rst2_ready", 64'(REQ_READY), 64'd0);
        chk("rst2_rsp_vld", 64'(RSP_VALID), 64'd0);
        repeat (2) @(negedge CLK);
        REQ_VALID = '0;
        RST_N     = 1'b1;
        repeat (4) @(negedge CLK);

        // Four reads from pointer 0, then two more while responses are queued
        for (int i = 0; i < N; i++) rd(i, AW'(i + 1), PRE + DW'(i + 1));
        cyc_chk("rr_c0", 4'b0011);
        cyc_chk("rr_c1", 4'b1100);
        rd(0, 10'd1, PRE + 32'd1);
        rd(1, 10'd2, PRE + 32'd2);
        cyc_chk("rr_c2_b_blocked", 4'b0001);
        cyc_chk("rr_c3", 4'b0010);
        drain();

        // Write/read to the same address: read deferred and sees new data
        set_req(0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF);
        rd(1, 10'd5, 32'hDEADBEEF);
        #1;
        chk("wr_we_a", 64'(WE_A), 64'd1);
        chk("wr_addr_a", 64'(ADDR_A), 64'd5);
        chk("wr_di_a", 64'(DI_A), 64'hDEADBEEF);
        chk("wr_b_idle_we", 64'(WE_B), 64'd0);
        chk("wr_b_idle_addr", 64'(ADDR_B), 64'd0);
        cyc_chk("conf_c0", 4'b0001);
        cyc_chk("conf_c1", 4'b0010);
        drain();

        // Two reads of the same address in one cycle
        set_req(0, 1'b1, 10'd7, 4'hF, 32'h7777_0007);
        cyc_chk("w7", 4'b0001);
        rd(2, 10'd7, 32'h7777_0007);
        rd(3, 10'd7, 32'h7777_0007);
        cyc_chk("same_rd", 4'b1100);
        drain();

        // Byte-enable merge
        set_req(1, 1'b1, 10'd9, 4'hF, 32'h1122_3344);
        cyc_chk("w9_full", 4'b0010);
        set_req(0, 1'b1, 10'd9, 4'h1, 32'h0000_00AA);
        cyc_chk("w9_be", 4'b0001);
        rd(3, 10'd9, 32'h1122_33AA);
        cyc_chk("r9", 4'b1000);
        drain();

        // Starvation bound: req1 conflicts with req0's repeated writes to addr 2
        rd(1, 10'd2, PRE + 32'd2);
        got = 1'b0;
        for (int k = 0; k < N && !got; k++) begin
            set_req(0, 1'b1, 10'd2, 4'hF, PRE + 32'd2);
            set_req(2, 1'b1, 10'd22, 4'hF, 32'h22);
            set_req(3, 1'b1, 10'd23, 4'hF, 32'h23);
            cyc(g);
            if (g[1]) got = 1'b1;
        end
        chk("starve_gnt", 64'(got), 64'd1);
        REQ_VALID = '0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
